// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults, types and constants for the regfile_mp slice.
// Contents : DEFAULT_DATA_W / DEFAULT_DEPTH / DEFAULT_ADDR_W localparams,
//            reg_addr_t / reg_data_t typedefs, ZERO_ADDR constant.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

  // Architectural register that may be hardwired to zero.
  localparam reg_addr_t ZERO_ADDR = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Bundles the read, write and issue signals of regfile_mp.
// Modports : master - decode/writeback side (drives addresses, data, issue)
//            slave  - register file side (drives rdata, rbusy, busy_vec)
// Signals  : raddr/rdata/rbusy (flattened, NUM_RD ports), we0/waddr0/wdata0,
//            we1/waddr1/wdata1, issue_valid/issue_addr, busy_vec
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
           issue_valid, issue_addr,
    input  rdata, rbusy, busy_vec
  );

  modport slave (
    input  raddr, we0, waddr0, wdata0, we1, waddr1, wdata1,
           issue_valid, issue_addr,
    output rdata, rbusy, busy_vec
  );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register busy bits tracking in-flight destinations.
// Ports    : clk, reset (async, active-low)
//            issue_valid_i/issue_addr_i - set busy at posedge
//            we0_i/waddr0_i, we1_i/waddr1_i - clear busy at posedge
//            busy_vec_o - registered scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              issue_valid_i,
  input  wire logic [ADDR_W-1:0] issue_addr_i,
  input  wire logic              we0_i,
  input  wire logic [ADDR_W-1:0] waddr0_i,
  input  wire logic              we1_i,
  input  wire logic [ADDR_W-1:0] waddr1_i,
  output logic      [DEPTH-1:0]  busy_vec_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears are applied first so that a same-cycle issue overrides them:
  // the new producer supersedes the one retiring this cycle.
  always_comb begin
    busy_d = busy_q;
    if (we0_i)         busy_d[waddr0_i]     = 1'b0;
    if (we1_i)         busy_d[waddr1_i]     = 1'b0;
    if (issue_valid_i) busy_d[issue_addr_i] = 1'b1;
    if (ZERO_REG != 0) busy_d[ADDR_W'(ZERO_ADDR)] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port integer register file with busy scoreboard.
//            NUM_RD combinational read ports, two write ports (W1 wins on
//            an address collision), optional write-through bypass.
// Ports    : clk, reset (async, active-low), bus (regfile_mp_if.slave)
// Macro    : REGFILE_BYPASS_EN - when defined, reads see same-cycle writes
//            (W1 over W0) and rbusy is dropped for a retiring register
//            unless it is being re-issued in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  wire logic  clk,
  input  wire logic  reset,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DEPTH-1:0]         busy_w;
  logic                     w0_ok;
  logic                     w1_ok;
  logic [NUM_RD*DATA_W-1:0] rdata_w;
  logic [NUM_RD-1:0]        rbusy_w;

  // A write to the hardwired zero register is dropped entirely.
  assign w0_ok = bus.we0 && !((ZERO_REG != 0) && (bus.waddr0 == ADDR_W'(ZERO_ADDR)));
  assign w1_ok = bus.we1 && !((ZERO_REG != 0) && (bus.waddr1 == ADDR_W'(ZERO_ADDR)));

  // W1 is written last so it overrides W0 on a shared address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (w0_ok) mem_q[bus.waddr0] <= bus.wdata0;
      if (w1_ok) mem_q[bus.waddr1] <= bus.wdata1;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .issue_valid_i (bus.issue_valid),
    .issue_addr_i  (bus.issue_addr),
    .we0_i         (bus.we0),
    .waddr0_i      (bus.waddr0),
    .we1_i         (bus.we1),
    .waddr1_i      (bus.waddr1),
    .busy_vec_o    (busy_w)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem_q[ra];
      rb = busy_w[ra];
`ifdef REGFILE_BYPASS_EN
      if (w1_ok && (bus.waddr1 == ra)) begin
        rd = bus.wdata1;
        if (!(bus.issue_valid && (bus.issue_addr == ra))) rb = 1'b0;
      end else if (w0_ok && (bus.waddr0 == ra)) begin
        rd = bus.wdata0;
        if (!(bus.issue_valid && (bus.issue_addr == ra))) rb = 1'b0;
      end
`endif
      // Zero register masks everything, including a re-issue to it.
      if ((ZERO_REG != 0) && (ra == ADDR_W'(ZERO_ADDR))) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata_w[k*DATA_W +: DATA_W] = rd;
    assign rbusy_w[k]                  = rb;
  end

  assign bus.rdata    = rdata_w;
  assign bus.rbusy    = rbusy_w;
  assign bus.busy_vec = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp. Two instances share the
//            stimulus: A = 32x32, 2 read ports, zero register on;
//            B = 16x64, 4 read ports, zero register off.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) ifa ();
  regfile_mp_if #(.DATA_W(64), .DEPTH(16), .NUM_RD(4)) ifb ();

  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  // Current-cycle stimulus (B uses the low 4 address bits and widened data)
  logic        s_we0, s_we1, s_iv;
  logic [4:0]  s_wa0, s_wa1, s_ia;
  logic [31:0] s_wd0, s_wd1;
  logic [4:0]  s_ra [4];

  // Reference architectural state
  logic [31:0] ma [32];
  bit          ba [32];
  logic [63:0] mb [16];
  bit          bb [16];

  function automatic logic [63:0] widen(logic [31:0] d);
    return {~d, d};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin ma[i] = '0; ba[i] = 0; end
    for (int i = 0; i < 16; i++) begin mb[i] = '0; bb[i] = 0; end
  endtask

  task automatic idle();
    s_we0 = 0; s_we1 = 0; s_iv = 0;
    s_wa0 = 0; s_wa1 = 0; s_ia = 0;
    s_wd0 = 0; s_wd1 = 0;
  endtask

  task automatic apply();
    ifa.we0 = s_we0; ifa.waddr0 = s_wa0; ifa.wdata0 = s_wd0;
    ifa.we1 = s_we1; ifa.waddr1 = s_wa1; ifa.wdata1 = s_wd1;
    ifa.issue_valid = s_iv; ifa.issue_addr = s_ia;
    ifa.raddr = {s_ra[1], s_ra[0]};
    ifb.we0 = s_we0; ifb.waddr0 = s_wa0[3:0]; ifb.wdata0 = widen(s_wd0);
    ifb.we1 = s_we1; ifb.waddr1 = s_wa1[3:0]; ifb.wdata1 = widen(s_wd1);
    ifb.issue_valid = s_iv; ifb.issue_addr = s_ia[3:0];
    ifb.raddr = {s_ra[3][3:0], s_ra[2][3:0], s_ra[1][3:0], s_ra[0][3:0]};
  endtask

  // Architectural effect of one clock edge: the younger result (W1) lands
  // last, a retiring write frees its register, a new issue re-claims it.
  task automatic model_commit();
    if (s_we0 && s_wa0 != 0) ma[s_wa0] = s_wd0;
    if (s_we1 && s_wa1 != 0) ma[s_wa1] = s_wd1;
    if (s_we0) ba[s_wa0] = 0;
    if (s_we1) ba[s_wa1] = 0;
    if (s_iv)  ba[s_ia]  = 1;
    ba[0] = 0;
    if (s_we0) mb[s_wa0[3:0]] = widen(s_wd0);
    if (s_we1) mb[s_wa1[3:0]] = widen(s_wd1);
    if (s_we0) bb[s_wa0[3:0]] = 0;
    if (s_we1) bb[s_wa1[3:0]] = 0;
    if (s_iv)  bb[s_ia[3:0]]  = 1;
  endtask

  function automatic logic [31:0] exp_rd_a(logic [4:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (s_we1 && s_wa1 == a) return s_wd1;
    if (s_we0 && s_wa0 == a) return s_wd0;
`endif
    return ma[a];
  endfunction

  function automatic logic exp_rb_a(logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (((s_we1 && s_wa1 == a) || (s_we0 && s_wa0 == a)) && !(s_iv && s_ia == a))
      return 1'b0;
`endif
    return ba[a];
  endfunction

  function automatic logic [63:0] exp_rd_b(logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    if (s_we1 && s_wa1[3:0] == a) return widen(s_wd1);
    if (s_we0 && s_wa0[3:0] == a) return widen(s_wd0);
`endif
    return mb[a];
  endfunction

  function automatic logic exp_rb_b(logic [3:0] a);
`ifdef REGFILE_BYPASS_EN
    if (((s_we1 && s_wa1[3:0] == a) || (s_we0 && s_wa0[3:0] == a)) &&
        !(s_iv && s_ia[3:0] == a))
      return 1'b0;
`endif
    return bb[a];
  endfunction

  task automatic check_all(string tag);
    logic [31:0] bva;
    logic [15:0] bvb;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_a_rdata%0d", tag, k), 64'(ifa.rdata[k*32 +: 32]), 64'(exp_rd_a(s_ra[k])));
      chk($sformatf("%s_a_rbusy%0d", tag, k), 64'(ifa.rbusy[k]), 64'(exp_rb_a(s_ra[k])));
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_b_rdata%0d", tag, k), ifb.rdata[k*64 +: 64], exp_rd_b(s_ra[k][3:0]));
      chk($sformatf("%s_b_rbusy%0d", tag, k), 64'(ifb.rbusy[k]), 64'(exp_rb_b(s_ra[k][3:0])));
    end
    for (int i = 0; i < 32; i++) bva[i] = ba[i];
    for (int i = 0; i < 16; i++) bvb[i] = bb[i];
    chk({tag, "_a_busy_vec"}, 64'(ifa.busy_vec), 64'(bva));
    chk({tag, "_b_busy_vec"}, 64'(ifb.busy_vec), 64'(bvb));
  endtask

  // One clock: drive after the falling edge, check just before the rising
  // edge (combinational reads and bypass), then advance the model.
  task automatic step(string tag);
    @(negedge clk);
    apply();
    #1;
    check_all(tag);
    @(posedge clk);
    model_commit();
  endtask

  task automatic set_ra(logic [4:0] a0, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3);
    s_ra[0] = a0; s_ra[1] = a1; s_ra[2] = a2; s_ra[3] = a3;
  endtask

  initial begin
    idle();
    set_ra(0, 1, 2, 3);
    apply();
    model_clear();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Reset state
    step("reset");
    set_ra(5, 31, 15, 8);
    step("reset2");

    // Write then asynchronous reset mid-cycle
    idle(); s_we0 = 1; s_wa0 = 5; s_wd0 = 32'hDEADBEEF; set_ra(5, 1, 5, 0);
    step("wr5");
    idle();
    step("rd5");
    @(negedge clk);
    apply();
    #2 reset = 1'b0;
    model_clear();
    #1 check_all("async_rst");
    #1 reset = 1'b1;
    @(posedge clk);

    // Write to register 0 (A: ignored, B: stored)
    idle(); s_we0 = 1; s_wa0 = 0; s_wd0 = 32'h1234; set_ra(0, 0, 0, 0);
    step("wr0");
    idle();
    step("rd0");

    // Both ports to the same address: W1 wins
    idle(); s_we0 = 1; s_wa0 = 7; s_wd0 = 32'h11; s_we1 = 1; s_wa1 = 7; s_wd1 = 32'h22;
    set_ra(7, 0, 7, 1);
    step("wr7");
    idle();
    step("rd7");

    // Scoreboard: issue, retire, issue+retire together
    idle(); s_iv = 1; s_ia = 9; set_ra(9, 7, 9, 7);
    step("iss9");
    idle();
    step("busy9");
    idle(); s_we0 = 1; s_wa0 = 9; s_wd0 = 32'hAB;
    step("wr9");
    idle();
    step("free9");
    idle(); s_iv = 1; s_ia = 9; s_we1 = 1; s_wa1 = 9; s_wd1 = 32'hCD;
    step("isswr9");
    idle();
    step("rebusy9");

    // Same-cycle read of a write (bypass or not depending on build)
    idle(); s_we0 = 1; s_wa0 = 3; s_wd0 = 32'h55; set_ra(3, 3, 3, 9);
    step("wr3");
    idle();
    step("rd3");

    // Issue to register 0 (A: ignored, B: tracked)
    idle(); s_iv = 1; s_ia = 0; set_ra(0, 3, 0, 9);
    step("iss0");
    idle();
    step("busy0");

    // Randomized traffic, addresses biased into a small window to collide
    for (int n = 0; n < 400; n++) begin
      logic narrow;
      narrow = ($urandom_range(0, 3) != 0);
      s_we0 = 1'($urandom_range(0, 1));
      s_we1 = 1'($urandom_range(0, 1));
      s_iv  = 1'($urandom_range(0, 1));
      s_wa0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_wa1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_ia  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      s_wd0 = $urandom;
      s_wd1 = $urandom;
      for (int k = 0; k < 4; k++)
        s_ra[k] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      step("rand");
    end

    idle();
    step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the Strontium integer pipeline.
- Provides NUM_RD read ports and two write ports (W0 = ALU writeback, W1 = load/MDU writeback).
- Contains a per-register busy scoreboard so decode can detect RAW hazards on in-flight destinations.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of architectural registers; power of two, at least 2
- ADDR_W, $clog2(DEPTH), register address width
- NUM_RD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- raddr  in  NUM_RD*ADDR_W  flattened read addresses; port k is bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  flattened read data
- rbusy  out  NUM_RD  read register has a pending producer
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- issue_valid  in  1  mark issue_addr busy
- issue_addr  in  ADDR_W  destination register of the issuing instruction
- busy_vec  out  DEPTH  full scoreboard, for debug and stall logic

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0; all busy bits = 0; therefore rdata = 0 and rbusy = 0.
- Reads are combinational. rdata[k] = reg[raddr[k]] and rbusy[k] = busy[raddr[k]], with bypass applied when enabled (see Optional Feature).
- Writes occur at posedge clk when weN=1.
- If ZERO_REG=1, writes to address 0 are ignored. Register 0 always reads 0 and its busy bit is constantly 0. This applies to rdata, rbusy and busy_vec bit 0.
- If we0 and we1 target the same address in one cycle, W1 wins. W1 carries the later, program-order-younger result.
- A write on either port clears busy[waddr] at the same posedge.
- issue_valid=1 sets busy[issue_addr] at posedge. Issue to address 0 is ignored when ZERO_REG=1.
- If issue and a write target the same address in the same cycle, set wins: a new producer supersedes the retiring one. The data write still happens.
- Issue to an already-busy register keeps it busy. There is no counting; the pipeline guarantees in-order writeback per register.
- Reset asserted mid-operation clears everything immediately, regardless of in-flight writes or issues.
- Width rule: no truncation. Address widths are exactly ADDR_W; out-of-range addresses cannot occur because DEPTH = 2^ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Read data is write-through. If a read address matches an active write in the same cycle, rdata returns that write's data, with W1 taking priority over W0.
  - rbusy[k] is forced to 0 on such a match, unless issue_valid targets the same address in that cycle.
  - Zero-register rules still apply.
- Undefined: reads return the stored value only; the new data is visible the cycle after the write.

Decomposition:
- Package regfile_pkg:
  - default DATA_W and DEPTH localparams
  - typedef reg_addr_t, ADDR_W bits
  - typedef reg_data_t, DATA_W bits
  - constant ZERO_ADDR = 0
- Sub-module regfile_scoreboard:
  - Inputs: clk, reset, issue_valid/issue_addr, both write enables/addresses.
  - Outputs: busy_vec.
  - Owns the set-wins rule and the address-0 mask.
- Top level holds the data array, write arbitration and the read/bypass muxes.

Test Plan:
- Reset → all registers read 0, busy_vec=0. Write 0xDEADBEEF to reg 5, then pulse reset low mid-cycle → reg 5 reads 0 immediately, before the next clk edge.
- we0=1 waddr0=0 wdata0=0x1234 → rdata for raddr=0 stays 0 with ZERO_REG=1; with ZERO_REG=0 it reads 0x1234 after the edge.
- we0 (reg 7 ← 0x11) and we1 (reg 7 ← 0x22) in the same cycle → reg 7 = 0x22.
- Issue reg 9 → rbusy=1 next cycle. Write reg 9 ← 0xAB → busy clears, data 0xAB. Issue reg 9 and write reg 9 in the same cycle → busy stays 1, data updated.
- Bypass build: write reg 3 ← 0x55 with raddr=3 in the same cycle → rdata=0x55 combinationally and rbusy=0. Non-bypass build: old value returned, 0x55 on the next cycle.
- NUM_RD=4, DATA_W=64, DEPTH=16 build: four ports read distinct registers after random writes → all match the reference model; busy_vec width is 16.
